// File: rtl/decode_pkg.sv
// decode_pkg: shared types and default constants for the decode_arb slice.
//   state_e    - arbiter sequencer states
//   *_DEF      - default parameter values for channel count, length width and
//                watchdog width
package decode_pkg;

  localparam int NCH_DEF   = 4;
  localparam int LEN_W_DEF = 16;
  localparam int TO_W_DEF  = 12;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/decode_arb_if.sv
// decode_arb_if: bundle between the decode job arbiter and its channels /
// shared LZS datapath.
//   master modport : channel + datapath side (drives req/len and datapath status)
//   slave modport  : arbiter side (drives grants, clear, last-word, completion)
// Signals:
//   req[NCH], len[NCH*LEN_W]                  job requests and lengths
//   ce[NCH], dp_clr, m_last                   grant / datapath control
//   m_src_getn, src_empty, stream_done, fo_empty  datapath status
//   job_done[NCH], job_err, busy              completion and status
interface decode_arb_if
  import decode_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic [NCH-1:0]       req;
  logic [NCH*LEN_W-1:0] len;
  logic [NCH-1:0]       ce;
  logic                 dp_clr;
  logic                 m_last;
  logic                 m_src_getn;
  logic                 src_empty;
  logic                 stream_done;
  logic                 fo_empty;
  logic [NCH-1:0]       job_done;
  logic                 job_err;
  logic                 busy;

  modport master (
    output req, len, m_src_getn, src_empty, stream_done, fo_empty,
    input  ce, dp_clr, m_last, job_done, job_err, busy
  );

  modport slave (
    input  req, len, m_src_getn, src_empty, stream_done, fo_empty,
    output ce, dp_clr, m_last, job_done, job_err, busy
  );

endinterface

// File: rtl/decode_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i[NCH] : request vector
//   ptr_i[PW]  : channel with highest priority this round
//   valid_o    : at least one request present
//   gnt_o[NCH] : one-hot winner, first set req at or after ptr_i with wrap
module rr_pick
  import decode_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int PW  = $clog2(NCH_DEF)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic           valid_o,
  output logic [NCH-1:0] gnt_o
);

  int idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr_i) + i) % NCH;
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decode_arb.sv
// decode_arb: job-level arbiter / sequencer for the shared LZS decode datapath.
// Grants one channel at a time (round-robin), drives its ce, counts consumed
// 64-bit words, flags the last word and waits for stream end + output drain.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : decode_arb_if slave modport (req/len in, ce/dp_clr/m_last out,
//              datapath status in, job_done/job_err/busy out)
// Optional feature: define DECODE_ARB_TIMEOUT_EN to add a TO_W-bit watchdog in
// RUN/FLUSH that ends a stalled job with job_err.
//
// state | meaning
// IDLE  | no grant; pick a winner when any req is set
// START | ce on for winner, dp_clr pulse, load word counter
// RUN   | count consumed words until the last one
// FLUSH | wait for stream_done and fo_empty together
// DONE  | job_done pulse, ce off, advance pointer
module decode_arb
  import decode_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int LEN_W = LEN_W_DEF
`ifdef DECODE_ARB_TIMEOUT_EN
  , parameter int TO_W = TO_W_DEF
`endif
) (
  input logic         clk,
  input logic         rst,
  decode_arb_if.slave bus
);

  localparam int PW = $clog2(NCH);

  state_e           state_q;
  logic [PW-1:0]    ptr_q, ptr_d, win_q;
  logic [LEN_W-1:0] len_q, rem_q, rem_d;
  logic             err_q;
  logic [NCH-1:0]   ce_q, job_done_q;
  logic             dp_clr_q, job_err_q;

  logic             pick_valid;
  logic [NCH-1:0]   pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic [LEN_W-1:0] pick_len;
  logic             word_take;
  logic             timeout;

  rr_pick #(.NCH(NCH), .PW(PW)) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .gnt_o   (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    pick_len = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = PW'(i);
        pick_len = bus.len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign word_take = (state_q == RUN) && !bus.m_src_getn && !bus.src_empty;
  // saturating decrement; remaining==0 never sees a take, but never wrap anyway
  assign rem_d     = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;
  assign ptr_d     = (win_q == PW'(NCH - 1)) ? '0 : win_q + PW'(1);

`ifdef DECODE_ARB_TIMEOUT_EN
  logic [TO_W-1:0] wd_q;
  logic            sd_q, fe_q;
  logic            wd_clr, wd_run;

  assign wd_run  = (state_q == RUN) || (state_q == FLUSH);
  assign wd_clr  = word_take || (bus.stream_done != sd_q) || (bus.fo_empty != fe_q);
  // fire on the edge where the count would reach all-ones
  assign timeout = wd_run && !wd_clr && (wd_q == {{(TO_W-1){1'b1}}, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
      sd_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      sd_q <= bus.stream_done;
      fe_q <= bus.fo_empty;
      if (wd_run && !wd_clr) wd_q <= wd_q + TO_W'(1);
      else                   wd_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      ce_q       <= '0;
      dp_clr_q   <= 1'b0;
      job_done_q <= '0;
      job_err_q  <= 1'b0;
    end else begin
      dp_clr_q   <= 1'b0;
      job_done_q <= '0;
      job_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            win_q    <= pick_idx;
            len_q    <= pick_len;
            ce_q     <= pick_gnt;
            dp_clr_q <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (len_q == '0) begin
            err_q      <= 1'b1;
            ce_q       <= '0;
            job_done_q <= ce_q;
            job_err_q  <= 1'b1;
            state_q    <= DONE;
          end else begin
            rem_q   <= len_q;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (word_take) begin
            rem_q <= rem_d;
            if (rem_q == LEN_W'(1)) state_q <= FLUSH;
          end else if (timeout) begin
            err_q      <= 1'b1;
            ce_q       <= '0;
            job_done_q <= ce_q;
            job_err_q  <= 1'b1;
            state_q    <= DONE;
          end
        end
        FLUSH: begin
          if (bus.stream_done && bus.fo_empty) begin
            ce_q       <= '0;
            job_done_q <= ce_q;
            job_err_q  <= err_q;
            state_q    <= DONE;
          end else if (timeout) begin
            err_q      <= 1'b1;
            ce_q       <= '0;
            job_done_q <= ce_q;
            job_err_q  <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ce       = ce_q;
  assign bus.dp_clr   = dp_clr_q;
  assign bus.job_done = job_done_q;
  assign bus.job_err  = job_err_q;
  // m_last holds through FLUSH so the datapath sees the final-word marker until release
  assign bus.m_last   = ((state_q == RUN) && (rem_q == LEN_W'(1))) || (state_q == FLUSH);
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_decode_arb.sv
// tb_decode_arb: directed self-checking bench for decode_arb.
module tb_decode_arb;

  localparam int NCH   = 4;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  decode_arb_if #(.NCH(NCH), .LEN_W(LEN_W)) bus ();

  decode_arb #(
    .NCH   (NCH),
    .LEN_W (LEN_W)
`ifdef DECODE_ARB_TIMEOUT_EN
    , .TO_W (4)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_len(input int ch, input int v);
    bus.len[ch*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic wait_ce(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (bus.ce == '0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.ce != '0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (bus.job_done == '0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.job_done != '0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int exp_rem;
    rst             = 1'b1;
    bus.req         = '0;
    bus.len         = '0;
    bus.m_src_getn  = 1'b1;
    bus.src_empty   = 1'b1;
    bus.stream_done = 1'b0;
    bus.fo_empty    = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_ce",       bus.ce,       0);
    check("rst_dp_clr",   bus.dp_clr,   0);
    check("rst_m_last",   bus.m_last,   0);
    check("rst_job_done", bus.job_done, 0);
    check("rst_job_err",  bus.job_err,  0);
    check("rst_busy",     bus.busy,     0);
    rst = 1'b0;
    tick();

    // single job, channel 2, len 3, source never empty
    set_len(2, 3);
    bus.m_src_getn = 1'b0;
    bus.src_empty  = 1'b0;
    bus.req        = 4'b0100;
    tick();
    check("t1_ce",      bus.ce,     4'b0100);
    check("t1_dp_clr",  bus.dp_clr, 1);
    check("t1_busy",    bus.busy,   1);
    tick();
    check("t1_dp_clr_off", bus.dp_clr, 0);
    check("t1_mlast_r3",   bus.m_last, 0);
    tick();
    check("t1_mlast_r2",   bus.m_last, 0);
    tick();
    check("t1_mlast_r1",   bus.m_last, 1);
    tick();
    check("t1_mlast_flush", bus.m_last, 1);
    bus.m_src_getn = 1'b1;
    repeat (4) tick();
    check("t1_no_done_yet", bus.job_done, 0);
    check("t1_ce_held",     bus.ce, 4'b0100);
    bus.stream_done = 1'b1;
    bus.fo_empty    = 1'b1;
    tick();
    check("t1_job_done", bus.job_done, 4'b0100);
    check("t1_job_err",  bus.job_err, 0);
    check("t1_ce_off",   bus.ce, 0);
    bus.req = '0;
    bus.stream_done = 1'b0;
    bus.fo_empty    = 1'b0;
    tick();
    check("t1_idle_busy", bus.busy, 0);
    check("t1_done_pulse", bus.job_done, 0);

    // round robin, all four channels with len 1, pointer at 0
    do_reset();
    for (int ch = 0; ch < NCH; ch++) set_len(ch, 1);
    bus.m_src_getn  = 1'b0;
    bus.src_empty   = 1'b0;
    bus.stream_done = 1'b1;
    bus.fo_empty    = 1'b1;
    bus.req         = 4'b1111;
    for (int k = 0; k < NCH; k++) begin
      wait_ce("rr_grant_wait", 10);
      check("rr_grant", bus.ce, 32'(1 << k));
      if (k == 3) bus.req[0] = 1'b1;
      wait_done("rr_done_wait", 10);
      check("rr_done", bus.job_done, 32'(1 << k));
      bus.req[k] = 1'b0;
      tick();
      check("rr_idle_gap", bus.busy, 0);
    end
    wait_ce("rr_wrap_wait", 10);
    check("rr_wrap_grant", bus.ce, 4'b0001);
    wait_done("rr_wrap_done_wait", 10);
    check("rr_wrap_done", bus.job_done, 4'b0001);
    bus.req = '0;
    tick();

    // zero-length job on channel 1 (pointer now 1)
    bus.stream_done = 1'b0;
    bus.fo_empty    = 1'b0;
    set_len(1, 0);
    bus.req = 4'b0010;
    tick();
    check("t3_ce",     bus.ce, 4'b0010);
    check("t3_mlast0", bus.m_last, 0);
    tick();
    check("t3_job_done", bus.job_done, 4'b0010);
    check("t3_job_err",  bus.job_err, 1);
    check("t3_mlast1",   bus.m_last, 0);
    check("t3_ce_off",   bus.ce, 0);
    bus.req = '0;
    tick();
    check("t3_done_clr", bus.job_done, 0);
    check("t3_err_clr",  bus.job_err, 0);

    // src_empty toggling, channel 2, len 4 (pointer now 2)
    set_len(2, 4);
    bus.m_src_getn = 1'b0;
    bus.src_empty  = 1'b1;
    bus.req        = 4'b0100;
    tick();
    check("t4_ce", bus.ce, 4'b0100);
    tick();
    exp_rem = 4;
    check("t4_mlast_start", bus.m_last, 0);
    for (int k = 0; k < 8; k++) begin
      bus.src_empty = (k % 2 == 0);
      tick();
      if (!bus.src_empty) exp_rem--;
      check("t4_mlast", bus.m_last, 32'(exp_rem <= 1));
    end
    bus.src_empty = 1'b0;
    repeat (2) tick();
    check("t4_flush_mlast", bus.m_last, 1);
    check("t4_flush_nodone", bus.job_done, 0);
    bus.stream_done = 1'b1;
    bus.fo_empty    = 1'b1;
    tick();
    check("t4_job_done", bus.job_done, 4'b0100);
    check("t4_job_err",  bus.job_err, 0);
    bus.req = '0;
    bus.stream_done = 1'b0;
    bus.fo_empty    = 1'b0;
    tick();

    // reset while in FLUSH, then pending req granted from pointer 0
    set_len(2, 1);
    set_len(1, 1);
    bus.m_src_getn = 1'b0;
    bus.src_empty  = 1'b0;
    bus.req        = 4'b0100;
    tick();
    tick();
    check("t5_mlast_run", bus.m_last, 1);
    tick();
    tick();
    check("t5_flush_busy", bus.busy, 1);
    check("t5_flush_ce",   bus.ce, 4'b0100);
    bus.req = 4'b1010;
    rst = 1'b1;
    #1;
    check("t5_rst_ce",       bus.ce, 0);
    check("t5_rst_mlast",    bus.m_last, 0);
    check("t5_rst_busy",     bus.busy, 0);
    check("t5_rst_job_done", bus.job_done, 0);
    check("t5_rst_job_err",  bus.job_err, 0);
    check("t5_rst_dp_clr",   bus.dp_clr, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t5_regrant", bus.ce, 4'b0010);
    check("t5_no_done", bus.job_done, 0);
    bus.stream_done = 1'b1;
    bus.fo_empty    = 1'b1;
    wait_done("t5_done_wait", 10);
    check("t5_job_done", bus.job_done, 4'b0010);
    bus.req = '0;
    bus.stream_done = 1'b0;
    bus.fo_empty    = 1'b0;
    tick();

`ifdef DECODE_ARB_TIMEOUT_EN
    // watchdog: one word then the source stalls (pointer now 2)
    begin
      int n;
      set_len(3, 5);
      bus.m_src_getn = 1'b0;
      bus.src_empty  = 1'b0;
      bus.req        = 4'b1000;
      tick();
      tick();
      tick();
      bus.m_src_getn = 1'b1;
      n = 0;
      while (bus.job_done == '0 && n < 40) begin
        tick();
        n++;
      end
      check("t6_to_cycles", n, 15);
      check("t6_to_done",   bus.job_done, 4'b1000);
      check("t6_to_err",    bus.job_err, 1);
      bus.req = '0;
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
